// File: rtl/mem_align_unit.sv
// Load/store alignment unit between EX/MEM and the memory stage: passes aligned
// requests through and splits misaligned ones into aligned word loads or byte stores.
package mem_align_pkg;
  localparam int unsigned MA_XLEN = 32;

  typedef struct packed {
    logic               valid;
    logic [MA_XLEN-1:0] addr;
    logic               rw;
    logic [1:0]         rw_size;
    logic [MA_XLEN-1:0] data;
    logic               ld_op_sign;
  } data_req_t;
endpackage

module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_SPLIT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  data_req_t       ex_data_req_i,
  output data_req_t       mem_data_req_o,
  input  logic            mem_stall_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] data_o,
  output logic            stall_o,
  output logic            misalign_o
);

  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST_B, DONE} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            mis_c;
  logic            busy_c;
  logic            fire_c;
  logic [XLEN-1:0] merged_c;
  logic [XLEN-1:0] ld_res_c;
  logic [7:0]      st_byte_c;
  logic [1:0]      last_c;

  assign mis_c = ex_data_req_i.valid &&
                 ((ex_data_req_i.rw_size == SZ_HALF && ex_data_req_i.addr[0]) ||
                  (ex_data_req_i.rw_size == SZ_WORD && ex_data_req_i.addr[1:0] != 2'b00));

  assign busy_c = (state_q == LD_LO) || (state_q == LD_HI) || (state_q == ST_B);
  assign fire_c = busy_c && !mem_stall_i && !flush_i;

  // Merge the two words and shift the requested bytes down to lane 0.
  assign merged_c  = XLEN'({mem_data_i, lo_q} >> {off_q, 3'b000});
  assign ld_res_c  = (size_q == SZ_HALF) ?
                     {{(XLEN-16){sign_q & merged_c[15]}}, merged_c[15:0]} : merged_c;
  assign st_byte_c = data_q[{cnt_q, 3'b000} +: 8];
  assign last_c    = (size_q == SZ_HALF) ? 2'd1 : 2'd3;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (mis_c && EN_SPLIT) begin
          addr_d  = ex_data_req_i.rw ? ex_data_req_i.addr : {ex_data_req_i.addr[XLEN-1:2], 2'b00};
          off_d   = ex_data_req_i.addr[1:0];
          size_d  = ex_data_req_i.rw_size;
          sign_d  = ex_data_req_i.ld_op_sign;
          data_d  = ex_data_req_i.data;
          cnt_d   = 2'd0;
          res_d   = '0;
          state_d = ex_data_req_i.rw ? ST_B : LD_LO;
        end
      end
      LD_LO: begin
        if (fire_c) begin
          lo_d    = mem_data_i;
          state_d = LD_HI;
        end
      end
      LD_HI: begin
        if (fire_c) begin
          res_d   = ld_res_c;
          state_d = DONE;
        end
      end
      ST_B: begin
        if (fire_c) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_c) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush abandons the sequence and drops any same-cycle completion.
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      lo_d    = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // Outputs are combinational so aligned traffic sees no added latency.
  always_comb begin
    mem_data_req_o = ex_data_req_i;
    data_o         = mem_data_i;
    stall_o        = mem_stall_i;
    misalign_o     = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (mis_c) begin
            mem_data_req_o.valid = 1'b0;
            if (EN_SPLIT) begin
              stall_o = 1'b1;
            end else begin
              misalign_o = 1'b1;
              stall_o    = 1'b0;
            end
          end
        end
        LD_LO, LD_HI: begin
          mem_data_req_o            = '0;
          mem_data_req_o.valid      = 1'b1;
          mem_data_req_o.rw_size    = SZ_WORD;
          mem_data_req_o.ld_op_sign = sign_q;
          mem_data_req_o.addr       = (state_q == LD_HI) ? addr_q + XLEN'(4) : addr_q;
          stall_o                   = 1'b1;
        end
        ST_B: begin
          mem_data_req_o         = '0;
          mem_data_req_o.valid   = 1'b1;
          mem_data_req_o.rw      = 1'b1;
          mem_data_req_o.rw_size = SZ_BYTE;
          mem_data_req_o.addr    = addr_q + XLEN'(cnt_q);
          mem_data_req_o.data    = {4{st_byte_c}};
          stall_o                = 1'b1;
        end
        DONE: begin
          mem_data_req_o.valid = 1'b0;
          stall_o              = 1'b0;
          data_o               = res_q;
        end
        default: ;
      endcase
      if (flush_i) mem_data_req_o.valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: passthrough, split loads/stores, flush, no-split mode.
module tb_mem_align_unit;
  import mem_align_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  data_req_t   ex;
  logic        mem_stall;
  logic [31:0] mem_data;

  data_req_t   req_o,  req_ns;
  logic [31:0] data_o, data_ns;
  logic        stall_o, stall_ns;
  logic        mis_o,  mis_ns;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [7:0] st_bytes [4];

  mem_align_unit #(.XLEN(32), .EN_SPLIT(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ex_data_req_i(ex),
    .mem_data_req_o(req_o), .mem_stall_i(mem_stall), .mem_data_i(mem_data),
    .data_o(data_o), .stall_o(stall_o), .misalign_o(mis_o)
  );

  mem_align_unit #(.XLEN(32), .EN_SPLIT(1'b0)) u_ns (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ex_data_req_i(ex),
    .mem_data_req_o(req_ns), .mem_stall_i(mem_stall), .mem_data_i(mem_data),
    .data_o(data_ns), .stall_o(stall_ns), .misalign_o(mis_ns)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic data_req_t mk(input logic v, input logic [31:0] a, input logic rw,
                                   input logic [1:0] sz, input logic [31:0] d, input logic s);
    data_req_t r;
    r.valid = v; r.addr = a; r.rw = rw; r.rw_size = sz; r.data = d; r.ld_op_sign = s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full misaligned load: latch cycle, LD_LO, LD_HI, DONE.
  task automatic ld_seq(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic s, input logic [31:0] lo, input logic [31:0] hi,
                        input logic [31:0] base, input logic [31:0] base4, input logic [31:0] exp);
    ex = mk(1'b1, a, 1'b0, sz, 32'h0, s); mem_stall = 1'b0; #1;
    chk({tag, "_idle_stall"}, 96'(stall_o), 96'(1'b1));
    tick();
    ex = mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0); mem_data = lo; #1;
    chk({tag, "_lo_addr"}, 96'(req_o.addr), 96'(base));
    tick();
    mem_data = hi; #1;
    chk({tag, "_hi_addr"}, 96'(req_o.addr), 96'(base4));
    tick();
    mem_data = 32'h0; #1;
    chk({tag, "_done_data"}, 96'(data_o), 96'(exp));
    chk({tag, "_done_stall"}, 96'(stall_o), 96'(1'b0));
    tick();
  endtask

  initial begin
    st_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b1; mem_data = 32'h12345678;
    ex = mk(1'b1, 32'h100, 1'b0, 2'b11, 32'h0, 1'b0);
    #2;
    chk("rst_req",   96'(req_o),   96'(ex));
    chk("rst_stall", 96'(stall_o), 96'(1'b1));
    chk("rst_data",  96'(data_o),  96'(32'h12345678));
    chk("rst_mis",   96'(mis_o),   96'(1'b0));
    tick(); tick();
    rst_n = 1'b1;

    // Aligned lw passes straight through.
    mem_stall = 1'b0; mem_data = 32'hDEADBEEF; #1;
    chk("al_req",   96'(req_o),   96'(ex));
    chk("al_stall", 96'(stall_o), 96'(1'b0));
    chk("al_data",  96'(data_o),  96'(32'hDEADBEEF));
    mem_stall = 1'b1; #1;
    chk("al_stall_hi", 96'(stall_o), 96'(1'b1));
    tick();
    mem_stall = 1'b0; #1;
    chk("al_req_next", 96'(req_o), 96'(ex));
    tick();

    // Misaligned lw 0x103 with one stalled LD_LO cycle.
    ex = mk(1'b1, 32'h103, 1'b0, 2'b11, 32'h0, 1'b0); #1;
    chk("lw_idle_stall", 96'(stall_o),     96'(1'b1));
    chk("lw_idle_valid", 96'(req_o.valid), 96'(1'b0));
    tick();
    ex = mk(1'b0, 32'hABC, 1'b1, 2'b01, 32'h55, 1'b1); mem_stall = 1'b1; #1;
    chk("lwlo_valid", 96'(req_o.valid),   96'(1'b1));
    chk("lwlo_addr",  96'(req_o.addr),    96'(32'h100));
    chk("lwlo_rw",    96'(req_o.rw),      96'(1'b0));
    chk("lwlo_size",  96'(req_o.rw_size), 96'(2'b11));
    chk("lwlo_stall", 96'(stall_o),       96'(1'b1));
    tick();
    mem_stall = 1'b0; mem_data = 32'h44332211; #1;
    chk("lwlo_addr2", 96'(req_o.addr), 96'(32'h100));
    tick();
    mem_data = 32'h88776655; #1;
    chk("lwhi_addr",  96'(req_o.addr), 96'(32'h104));
    chk("lwhi_stall", 96'(stall_o),    96'(1'b1));
    tick();
    mem_data = 32'h0; mem_stall = 1'b1; #1;
    chk("lw_done_valid", 96'(req_o.valid), 96'(1'b0));
    chk("lw_done_stall", 96'(stall_o),     96'(1'b0));
    chk("lw_done_data",  96'(data_o),      96'(32'h77665544));
    tick();
    mem_stall = 1'b0;

    ld_seq("lh",   32'h1FF, 2'b10, 1'b1, 32'h80112233, 32'h445566FF, 32'h1FC, 32'h200, 32'hFFFFFF80);
    ld_seq("lhu",  32'h1FF, 2'b10, 1'b0, 32'h80112233, 32'h445566FF, 32'h1FC, 32'h200, 32'h0000FF80);
    ld_seq("wrap", 32'hFFFFFFFF, 2'b10, 1'b0, 32'hAB000000, 32'h000000CD,
           32'hFFFFFFFC, 32'h0, 32'h0000CDAB);

    // Misaligned sw 0x201 split into four byte stores.
    ex = mk(1'b1, 32'h201, 1'b1, 2'b11, 32'hAABBCCDD, 1'b0); #1;
    chk("st_idle_stall", 96'(stall_o),     96'(1'b1));
    chk("st_idle_valid", 96'(req_o.valid), 96'(1'b0));
    tick();
    ex = mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mem_stall = 1'b1; #1;
        chk("st_hold_addr", 96'(req_o.addr), 96'(32'h202));
        tick();
        mem_stall = 1'b0;
      end
      #1;
      chk($sformatf("st%0d_valid", i), 96'(req_o.valid),   96'(1'b1));
      chk($sformatf("st%0d_addr", i),  96'(req_o.addr),    96'(32'h201 + 32'(i)));
      chk($sformatf("st%0d_rw", i),    96'(req_o.rw),      96'(1'b1));
      chk($sformatf("st%0d_size", i),  96'(req_o.rw_size), 96'(2'b01));
      chk($sformatf("st%0d_data", i),  96'(req_o.data),    96'({4{st_bytes[i]}}));
      chk($sformatf("st%0d_stall", i), 96'(stall_o),       96'(1'b1));
      tick();
    end
    #1;
    chk("st_done_valid", 96'(req_o.valid), 96'(1'b0));
    chk("st_done_stall", 96'(stall_o),     96'(1'b0));
    chk("st_done_data",  96'(data_o),      96'(32'h0));
    tick();

    // Flush in LD_HI while memory is stalled.
    ex = mk(1'b1, 32'h103, 1'b0, 2'b11, 32'h0, 1'b0); #1;
    tick();
    ex = mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0); mem_data = 32'h11111111; #1;
    tick();
    mem_stall = 1'b1; flush = 1'b1; #1;
    chk("fl_valid", 96'(req_o.valid), 96'(1'b0));
    tick();
    flush = 1'b0; mem_stall = 1'b0; mem_data = 32'hCAFEF00D;
    ex = mk(1'b1, 32'h300, 1'b0, 2'b11, 32'h0, 1'b0); #1;
    chk("fl_req",   96'(req_o),   96'(ex));
    chk("fl_stall", 96'(stall_o), 96'(1'b0));
    chk("fl_data",  96'(data_o),  96'(32'hCAFEF00D));
    tick();

    // No-split instance flags misaligned requests.
    ex = mk(1'b1, 32'h102, 1'b0, 2'b11, 32'h0, 1'b0); mem_stall = 1'b1; #1;
    chk("ns_mis",   96'(mis_ns),       96'(1'b1));
    chk("ns_valid", 96'(req_ns.valid), 96'(1'b0));
    chk("ns_stall", 96'(stall_ns),     96'(1'b0));
    tick();
    ex = mk(1'b1, 32'h104, 1'b0, 2'b11, 32'h0, 1'b0); mem_stall = 1'b0; #1;
    chk("ns_al_mis",   96'(mis_ns),   96'(1'b0));
    chk("ns_al_req",   96'(req_ns),   96'(ex));
    chk("ns_al_stall", 96'(stall_ns), 96'(1'b0));
    tick();
    ex = mk(1'b1, 32'h101, 1'b1, 2'b10, 32'h1234, 1'b0); #1;
    chk("ns_sh_mis", 96'(mis_ns), 96'(1'b1));
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Sits between the EX/MEM pipe register and the memory stage.
- Aligned requests pass straight through to the memory stage.
- Misaligned loads are split into two aligned word loads, and the two words are merged, shifted and extended.
- Misaligned stores are split into sequential byte stores.
- The pipeline is held for the whole sequence.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- EN_SPLIT, 1, 1 = split misaligned accesses; 0 = flag `misalign_o` and suppress the access.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `flush_i`  in  1  pipeline/cache flush; aborts any sequence.
- `ex_data_req_i`  in  data_req_t  request from EX (valid, addr, rw, rw_size, data, ld_op_sign).
- `mem_data_req_o`  out  data_req_t  request driven to the memory stage.
- `mem_stall_i`  in  1  memory stage busy (dmiss stall).
- `mem_data_i`  in  XLEN  load data from the memory stage.
- `data_o`  out  XLEN  final load result to writeback.
- `stall_o`  out  1  pipeline hold request.
- `misalign_o`  out  1  misaligned access flagged (EN_SPLIT=0 only).

Behaviour:
- rw_size encoding: 01 = byte, 10 = half, 11 = word.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0. Bytes are never misaligned.
- Sub-access completion: a sub-access completes in a cycle where it is driven valid and `mem_stall_i`=0. `mem_data_i` is sampled in that cycle.
- Consecutive sub-accesses always differ in addr or rw_size, so the memory stage fires each one.
- FSM states: IDLE, LD_LO, LD_HI, ST_B, DONE.
- IDLE, request not valid, or aligned:
  - `mem_data_req_o` = `ex_data_req_i`, combinationally.
  - `data_o` = `mem_data_i`; `stall_o` = `mem_stall_i`.
- IDLE, valid misaligned load (EN_SPLIT=1):
  - Latch base = addr & ~3, off = addr[1:0], size, sign.
  - Go to LD_LO. `stall_o`=1 from this cycle.
- LD_LO:
  - Drive valid, rw=0, rw_size=11, addr=base.
  - On completion: lo_q ← `mem_data_i`; go to LD_HI.
- LD_HI:
  - Drive valid, rw=0, rw_size=11, addr=base+4 (32-bit wrap; 0xFFFFFFFC+4 → 0x0).
  - On completion: res_q ← extend(({`mem_data_i`,lo_q} >> 8·off)[size bits], sign); go to DONE.
- IDLE, valid misaligned store:
  - Latch addr, data, nbytes (2 for half, 4 for word), cnt=0.
  - Go to ST_B.
- ST_B:
  - Drive valid, rw=1, rw_size=01, addr=addr_q+cnt.
  - data = byte cnt of data_q replicated into all four lanes.
  - On completion: cnt++. If cnt==nbytes-1 go to DONE.
- DONE:
  - `mem_data_req_o`.valid=0; `stall_o`=0; `data_o`=res_q (stores: 0).
  - Next state: IDLE.
  - Holding valid low for one cycle guarantees the memory stage sees a fresh valid edge for the next request, even at the same address.
- `stall_o`=1 in LD_LO, LD_HI and ST_B regardless of `mem_stall_i`. Upstream fields may change freely while in these states; only latched copies are used.
- EN_SPLIT=0: a misaligned valid request → `misalign_o`=1 combinationally, `mem_data_req_o`.valid=0, `stall_o`=0. The FSM stays in IDLE.
- `flush_i`=1: next state is IDLE, and cnt, lo_q and res_q are cleared. In the flush cycle `mem_data_req_o`.valid=0. A completion in the same cycle is discarded.
- Reset (synchronous, `rst_ni`=0): state IDLE, all latches 0. Mid-sequence reset abandons the sequence; partial stores already issued are not undone.
- Reset output values: `mem_data_req_o` = `ex_data_req_i` passthrough; `stall_o` = `mem_stall_i`; `misalign_o`=0; `data_o` = `mem_data_i`.

Test Plan:
- Aligned lw 0x100 with hit; memory drives 0xDEADBEEF → passthrough, `stall_o` follows `mem_stall_i`, `data_o`=0xDEADBEEF, no extra cycles.
- Misaligned lw 0x103, word@0x100=0x44332211, word@0x104=0x88776655 → two word reads (0x100, 0x104), DONE `data_o`=0x77665544, `stall_o` low only in DONE.
- Misaligned lh signed 0x1FF, word@0x1FC=0x80xxxxxx, word@0x200=0xxxxxxxFF → `data_o`=0xFFFFFF80; same access with lhu → 0x0000FF80.
- Misaligned sw 0x201 data=0xAABBCCDD → four byte stores: 0x201/DD, 0x202/CC, 0x203/BB, 0x204/AA, each replicated in all lanes; `stall_o` high until DONE.
- `flush_i` asserted during LD_HI while `mem_stall_i`=1 → next cycle IDLE, no DONE, `data_o` is passthrough.
- EN_SPLIT=0, lw 0x102 → `misalign_o`=1, downstream valid=0, `stall_o`=0; aligned lw 0x104 → `misalign_o`=0.
